// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_gen_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A zero-length field is treated as one so every train has visible edges.
  function automatic logic [31:0] nz_fix(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module phase_counter
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Programmable pulse train generator: N pulses, W cycles high, G cycles low.
// Optional build macro PULSE_TRAIN_GENERATOR_RESTART_EN lets a start abort a
// running train and begin a fresh one.
//
// state | meaning
// IDLE  | waiting for start
// HIGH  | output high, phase counter timing the pulse width
// LOW   | output low, phase counter timing the gap (also the forced low
//       | cycle after a restart from HIGH)
// DONE  | single cycle with done strobe; a new start is accepted here
module pulse_train_generator
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  output logic             ready,
  output logic             busy,
  output logic             out,
  output logic             done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] w_rel, g_rel;
  logic [CNT_W-1:0] w_fix, g_fix, n_fix;
  logic [CNT_W-1:0] ph_val;
  logic             ph_load, ph_en, ph_zero;
  logic             pc_load, pc_en, pc_zero;
  logic             latch;

  // Counters reload with length-1 so that zero marks the final cycle of a phase.
  assign w_fix = CNT_W'(nz_fix(32'(width)) - 32'd1);
  assign g_fix = CNT_W'(nz_fix(32'(gap)) - 32'd1);
  assign n_fix = CNT_W'(nz_fix(32'(count)) - 32'd1);

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .en       (ph_en),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  // Pulse counter holds the pulses still to come after the current one.
  phase_counter #(.CNT_W(CNT_W)) u_pulses (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .en       (pc_en),
    .load_val (n_fix),
    .zero     (pc_zero)
  );

`ifdef PULSE_TRAIN_GENERATOR_RESTART_EN
  assign ready = 1'b1;
`else
  assign ready = (state == IDLE) || (state == DONE);
`endif

  // Next-state and counter control.
  always_comb begin
    state_nxt = state;
    ph_load   = 1'b0;
    ph_en     = 1'b0;
    ph_val    = '0;
    pc_load   = 1'b0;
    pc_en     = 1'b0;
    latch     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = HIGH;
          ph_load   = 1'b1;
          ph_val    = w_fix;
          pc_load   = 1'b1;
          latch     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      HIGH: begin
`ifdef PULSE_TRAIN_GENERATOR_RESTART_EN
        if (start) begin
          // One forced low cycle keeps the rising edge of the new train visible.
          state_nxt = LOW;
          ph_load   = 1'b1;
          ph_val    = '0;
          pc_load   = 1'b1;
          latch     = 1'b1;
        end else
`endif
        if (ph_zero) begin
          if (pc_zero) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LOW;
            ph_load   = 1'b1;
            ph_val    = g_rel;
            pc_en     = 1'b1;
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      LOW: begin
`ifdef PULSE_TRAIN_GENERATOR_RESTART_EN
        if (start) begin
          state_nxt = HIGH;
          ph_load   = 1'b1;
          ph_val    = w_fix;
          pc_load   = 1'b1;
          latch     = 1'b1;
        end else
`endif
        if (ph_zero) begin
          state_nxt = HIGH;
          ph_load   = 1'b1;
          ph_val    = w_rel;
        end else begin
          ph_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      out   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= (state_nxt == HIGH);
      busy  <= (state_nxt == HIGH) || (state_nxt == LOW);
      done  <= (state_nxt == DONE);
    end
  end

  // Width and gap reload values captured when a train is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_rel <= '0;
      g_rel <= '0;
    end else if (latch) begin
      w_rel <= w_fix;
      g_rel <= g_fix;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator with a queue-based train model.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] width = '0, gap = '0, count = '0;
  logic       ready, busy, out, done;

  int errors = 0;
  int checks = 0;

  // Expected {out,busy,done} for upcoming cycles; empty means idle.
  logic [2:0] exp_q[$];

  pulse_train_generator #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .width (width),
    .gap   (gap),
    .count (count),
    .ready (ready),
    .busy  (busy),
    .out   (out),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic void push_train(input int w, input int g, input int n);
    int wf, gf, nf;
    wf = (w == 0) ? 1 : w;
    gf = (g == 0) ? 1 : g;
    nf = (n == 0) ? 1 : n;
    for (int p = 0; p < nf; p++) begin
      for (int i = 0; i < wf; i++) exp_q.push_back(3'b110);
      if (p < nf - 1)
        for (int i = 0; i < gf; i++) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
  endfunction

  // Called at a falling edge: samples DUT, advances model, drives inputs, waits a cycle.
  task automatic step(input logic st, input logic [7:0] w, input logic [7:0] g,
                      input logic [7:0] n, output logic [3:0] obsv,
                      output logic [3:0] expv);
    logic [2:0] cur;
    logic       mready;
    obsv   = {ready, out, busy, done};
    cur    = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
    mready = (exp_q.size() == 0);
`ifdef PULSE_TRAIN_GENERATOR_RESTART_EN
    mready = 1'b1;
`endif
    expv  = {mready, cur};
    start = st;
    width = w;
    gap   = g;
    count = n;
    if (st && mready) begin
`ifdef PULSE_TRAIN_GENERATOR_RESTART_EN
      if (cur[1]) begin
        exp_q.delete();
        if (cur[2]) exp_q.push_back(3'b010);
      end
`endif
      push_train(int'(w), int'(g), int'(n));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] o, e;
    #2;
    checks++;
    if ({out, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000", {out, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'd0, 8'd0, 8'd0, o, e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_release rdy/out/busy/done got %b want %b", o, e);
    end
  endtask

  task automatic test_basic();
    logic [3:0] o, e;
    int nbusy;
    nbusy = 0;
    step(1'b1, 8'd1, 8'd1, 8'd3, o, e);
    checks++;
    if (o !== e) begin errors++; $display("FAIL basic_accept got %b want %b", o, e); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'd1, 8'd1, 8'd3, o, e);
      if (o[1]) nbusy++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL basic_w1g1n3 cyc %0d got %b want %b", i, o, e); end
    end
    checks++;
    if (nbusy !== 5) begin errors++; $display("FAIL basic_busy_len got %0d want 5", nbusy); end
  endtask

  task automatic test_w3g2n2();
    logic [3:0] o, e;
    int nbusy, ndone;
    nbusy = 0;
    ndone = 0;
    step(1'b1, 8'd3, 8'd2, 8'd2, o, e);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 8'd9, 8'd9, 8'd9, o, e);
      if (o[1]) nbusy++;
      if (o[0]) ndone++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL w3g2n2 cyc %0d got %b want %b", i, o, e); end
    end
    checks++;
    if (nbusy !== 3 * 2 + 2) begin errors++; $display("FAIL w3g2n2_busy_len got %0d want 8", nbusy); end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL w3g2n2_done_cnt got %0d want 1", ndone); end
  endtask

  task automatic test_zero_fields();
    logic [3:0] o, e;
    int nbusy;
    nbusy = 0;
    step(1'b1, 8'd0, 8'd0, 8'd0, o, e);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'd0, 8'd0, 8'd0, o, e);
      if (o[1]) nbusy++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL zero_fields cyc %0d got %b want %b", i, o, e); end
    end
    checks++;
    if (nbusy !== 1) begin errors++; $display("FAIL zero_fields_busy_len got %0d want 1", nbusy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] o, e;
    int ndone;
    ndone = 0;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 8'd2, 8'd1, 8'd1, o, e);
      if (o[0]) ndone++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back cyc %0d got %b want %b", i, o, e); end
    end
    checks++;
    if (ndone !== 4) begin errors++; $display("FAIL back_to_back_done_cnt got %0d want 4", ndone); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'd0, 8'd0, 8'd0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back_drain cyc %0d got %b want %b", i, o, e); end
    end
  endtask

  task automatic test_mid_train_start();
    logic [3:0] o, e;
    step(1'b1, 8'd2, 8'd2, 8'd3, o, e);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 8'd0, 8'd0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL mid_start_pre cyc %0d got %b want %b", i, o, e); end
    end
    step(1'b1, 8'd1, 8'd1, 8'd1, o, e);
    checks++;
    if (o !== e) begin errors++; $display("FAIL mid_start_req got %b want %b", o, e); end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'd0, 8'd0, 8'd0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL mid_start_post cyc %0d got %b want %b", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_train();
    logic [3:0] o, e;
    int ndone;
    ndone = 0;
    step(1'b1, 8'd4, 8'd1, 8'd2, o, e);
    step(1'b0, 8'd0, 8'd0, 8'd0, o, e);
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_mid_high got %b want %b", o, e); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({ready, out, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_async got %b want 1000", {ready, out, busy, done});
    end
    exp_q.delete();
    #1 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'd0, 8'd0, 8'd0, o, e);
      if (o[0]) ndone++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_mid_after cyc %0d got %b want %b", i, o, e); end
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL reset_mid_done got %0d want 0", ndone); end
  endtask

  task automatic test_random();
    logic [3:0] o, e;
    logic [7:0] w, g, n;
    logic       st;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 3) == 0);
      w  = 8'($urandom_range(0, 4));
      g  = 8'($urandom_range(0, 4));
      n  = 8'($urandom_range(0, 4));
      step(st, w, g, n, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL random cyc %0d got %b want %b", i, o, e); end
    end
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 8'd0, 8'd0, 8'd0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL random_drain cyc %0d got %b want %b", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w3g2n2();
    test_zero_fields();
    test_back_to_back();
    test_mid_train_start();
    test_reset_mid_train();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
